regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Writer side of the 8-bit register file interface. Accepts results from the ALU and load path over a valid/ready handshake, buffers them in a small in-order queue, and drives the register file write port (we/rd/data) plus the PC latch strobe, one write per cycle.
- Also reports read-after-write hazards on the current source selects so the sequencer can stall.

Parameters:
- DATA_W, 8, result/register data width
- ADDR_W, 3, register index width (8 registers; reg0 = PC)
- DEPTH, 4, queue entries (power of two, >= 2)

Ports:
- clka  in  1  system clock, all state updates on rising edge
- reset_in  in  1  synchronous active-high reset
- res_valid_in  in  1  producer has a result
- res_ready_out  out  1  queue can accept this cycle
- res_rd_in  in  ADDR_W  destination register of result
- res_data_in  in  DATA_W  result value
- res_pc_in  in  1  result is a PC update (rd must be 0)
- flush_in  in  1  discard all pending, unissued results
- sr1_in  in  ADDR_W  source select 1 being read this cycle
- sr2_in  in  ADDR_W  source select 2 being read this cycle
- we_reg_out  out  1  register file write enable (registered)
- rd_out  out  ADDR_W  register file destination (registered)
- data_out  out  DATA_W  register file write data (registered)
- pc_latch_out  out  1  PC latch strobe, coincident with the reg0 write (registered)
- stall_out  out  1  hazard on sr1_in/sr2_in (combinational)
- count_out  out  ADDR_W  entries queued, 0..DEPTH

Behaviour:
- Clock and reset: one clock, clka. Reset is synchronous and active-high on reset_in.
- Reset: queue emptied, head/tail = 0, state IDLE. Outputs go to we_reg_out=0, rd_out=0, data_out=0, pc_latch_out=0, count_out=0, res_ready_out=1.
- Reset priority: reset_in has priority over flush_in and the handshake. Reset in mid-drain drops every queued entry.
- Accept rule: an entry is accepted at an edge when res_valid_in=1 and res_ready_out=1.
  - res_ready_out = (count < DEPTH) and not flush_in.
  - A push while full is not possible. A push and a pop in the same cycle are allowed when count < DEPTH; count is unchanged.
- Issue: entries issue strictly in acceptance order.
  - Output registers load from the head at the edge where the pop occurs.
  - An entry accepted at edge k into an empty queue in IDLE is visible as we_reg_out=1 from edge k+1 to edge k+2. Latency is 1 cycle, with no combinational bypass.
- FSM states:
  - IDLE: we_reg_out=0. Moves to ISSUE when an edge occurs with count>0.
  - ISSUE: pops one entry per edge and drives we_reg_out=1 with the popped rd/data.
    - If the popped entry has pc=1, pc_latch_out=1 for that cycle, and the next state is PC_BUBBLE.
    - Otherwise stays in ISSUE while entries remain, or goes to IDLE when the queue drains.
  - PC_BUBBLE: exactly one cycle with we_reg_out=0 and pc_latch_out=0, so fetch can settle. Then goes to ISSUE if count>0, else IDLE.
- Flush: flush_in=1 at an edge clears every queued entry, sets count=0, blocks that cycle's accept, and enters IDLE. The write already on the outputs completes; the next cycle has we_reg_out=0.
- Hazard: stall_out=1 if sr1_in or sr2_in equals the rd of any valid queued entry, or equals rd_out while we_reg_out=1. Reg0 is included.
- res_pc_in=1 with res_rd_in != 0: the entry is written as rd=0, pc=1, i.e. the rd field is forced to 0.
- Pointers are ADDR_W-independent, log2(DEPTH) bits wide, and wrap modulo DEPTH.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: an accepted result whose rd matches the tail entry (newest, unissued, pc=0, and not being popped this edge) overwrites that entry's data. count does not change; res_ready_out stays 1 even when full for such a match.
- Undefined: every accepted result allocates a new entry.

Test Plan:
- Reset then idle: reset_in=1 for 1 edge -> we_reg_out=0, count_out=0, res_ready_out=1, stall_out=0 with sr1_in=sr2_in=0.
- Single write: push rd=1, data=0x01 at edge k -> we_reg_out=1, rd_out=1, data_out=0x01 between edges k+1 and k+2, then IDLE.
- Back-to-back fill: push rd=1..4 (data 0x0A..0x0D) with a pop stalled by a preceding PC entry -> count_out reaches 4, res_ready_out=0, writes emerge in order 1,2,3,4 one per cycle.
- PC update: push rd=0, data=0x08, pc=1, then rd=2, data=0x02 -> pc_latch_out=1 with the reg0 write, one bubble cycle with we_reg_out=0, then rd=2 written.
- Hazard and flush: queue rd=3, sr1_in=3 -> stall_out=1. Assert flush_in -> count_out=0 next cycle, no write to reg3, stall_out=0.
- Coalesce (WB_COALESCE_EN): push rd=5, data=0x10 then rd=5, data=0x20 while blocked -> count_out=1, single write rd=5, data=0x20. Without the macro: count_out=2, two writes.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order writeback queue driving the register file write port and PC latch; `define WB_COALESCE_EN to merge same-rd results into the tail entry
module regfile_writeback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clka,
  input  logic              reset_in,
  input  logic              res_valid_in,
  output logic              res_ready_out,
  input  logic [ADDR_W-1:0] res_rd_in,
  input  logic [DATA_W-1:0] res_data_in,
  input  logic              res_pc_in,
  input  logic              flush_in,
  input  logic [ADDR_W-1:0] sr1_in,
  input  logic [ADDR_W-1:0] sr2_in,
  output logic              we_reg_out,
  output logic [ADDR_W-1:0] rd_out,
  output logic [DATA_W-1:0] data_out,
  output logic              pc_latch_out,
  output logic              stall_out,
  output logic [ADDR_W-1:0] count_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, PC_BUBBLE} state_t;

  logic [ADDR_W-1:0] q_rd   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_pc, q_vld;
  logic [PW-1:0]     head, tail, tail_idx;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] in_rd;
  logic              pop, match, merge, push;
  state_t            state, state_nxt;

  always_comb begin
    in_rd = res_pc_in ? '0 : res_rd_in;
    tail_idx = tail - 1'b1;
    pop = (count != '0) && !flush_in && !(state == ISSUE && pc_latch_out);
`ifdef WB_COALESCE_EN
    match = (count != '0) && !res_pc_in && !q_pc[tail_idx] && (q_rd[tail_idx] == res_rd_in)
            && !(pop && count == CW'(1));
`else
    match = 1'b0;
`endif
    res_ready_out = !flush_in && (count != CW'(DEPTH) || match);
    merge = res_valid_in && res_ready_out && match;
    push = res_valid_in && res_ready_out && !match;
    count_out = ADDR_W'(count);
  end

  always_comb begin
    stall_out = we_reg_out && (rd_out == sr1_in || rd_out == sr2_in);
    for (int i = 0; i < DEPTH; i++)
      stall_out = stall_out | (q_vld[i] && (q_rd[i] == sr1_in || q_rd[i] == sr2_in));
  end

  // a PC write is always followed by one idle bubble so fetch can settle
  always_comb
    state_nxt = flush_in ? IDLE :
                pop ? ISSUE :
                (state == ISSUE && pc_latch_out) ? PC_BUBBLE : IDLE;

  always_ff @(posedge clka)
    if (reset_in) state <= IDLE;
    else state <= state_nxt;

  always_ff @(posedge clka) begin
    if (push) begin
      q_rd[tail] <= in_rd;
      q_data[tail] <= res_data_in;
      q_pc[tail] <= res_pc_in;
    end
    if (merge) q_data[tail_idx] <= res_data_in;
  end

  always_ff @(posedge clka)
    if (reset_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      q_vld <= '0;
      we_reg_out <= 1'b0;
      rd_out <= '0;
      data_out <= '0;
      pc_latch_out <= 1'b0;
    end else begin
      we_reg_out <= pop;
      pc_latch_out <= pop && q_pc[head];
      if (pop) begin
        rd_out <= q_rd[head];
        data_out <= q_data[head];
      end
      if (flush_in) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        q_vld <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop) head <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        q_vld <= (q_vld | (DEPTH'(push) << tail)) & ~(DEPTH'(pop) << head);
      end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: queue-based reference model checked every cycle, plus directed literal expectations
module tb_regfile_writeback;
  logic       clka = 1'b0;
  logic       reset_in, res_valid_in, res_pc_in, flush_in;
  logic [2:0] res_rd_in, sr1_in, sr2_in;
  logic [7:0] res_data_in;
  logic       res_ready_out, we_reg_out, pc_latch_out, stall_out;
  logic [2:0] rd_out, count_out;
  logic [7:0] data_out;

  typedef struct {logic [2:0] rd; logic [7:0] data; logic pc;} ent_t;
  ent_t       q[$];
  logic       m_we, m_pc;
  logic [2:0] m_rd;
  logic [7:0] m_data;
  int         n_pass = 0, n_total = 0;

  regfile_writeback dut (
    .clka(clka), .reset_in(reset_in), .res_valid_in(res_valid_in), .res_ready_out(res_ready_out),
    .res_rd_in(res_rd_in), .res_data_in(res_data_in), .res_pc_in(res_pc_in), .flush_in(flush_in),
    .sr1_in(sr1_in), .sr2_in(sr2_in), .we_reg_out(we_reg_out), .rd_out(rd_out), .data_out(data_out),
    .pc_latch_out(pc_latch_out), .stall_out(stall_out), .count_out(count_out)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_pop();
    return q.size() > 0 && !flush_in && !m_pc;
  endfunction

  function automatic bit m_match();
`ifdef WB_COALESCE_EN
    if (q.size() == 0 || res_pc_in) return 1'b0;
    if (q[q.size()-1].pc || q[q.size()-1].rd != res_rd_in) return 1'b0;
    return !(m_pop() && q.size() == 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return !flush_in && (q.size() < 4 || m_match());
  endfunction

  function automatic bit m_stall();
    bit s;
    s = m_we && (m_rd == sr1_in || m_rd == sr2_in);
    foreach (q[i]) if (q[i].rd == sr1_in || q[i].rd == sr2_in) s = 1'b1;
    return s;
  endfunction

  task automatic model_step();
    bit p, mt, acc;
    ent_t e;
    if (reset_in) begin
      q.delete();
      m_we = 0; m_pc = 0; m_rd = 0; m_data = 0;
    end else begin
      p = m_pop();
      mt = m_match();
      acc = res_valid_in && m_ready();
      if (p) begin
        e = q.pop_front();
        m_we = 1; m_rd = e.rd; m_data = e.data; m_pc = e.pc;
      end else begin
        m_we = 0; m_pc = 0;
      end
      if (flush_in) q.delete();
      else if (acc && mt) q[q.size()-1].data = res_data_in;
      else if (acc) begin
        e.rd = res_pc_in ? 3'd0 : res_rd_in;
        e.data = res_data_in;
        e.pc = res_pc_in;
        q.push_back(e);
      end
    end
  endtask

  task automatic clk_edge();
    @(posedge clka);
    model_step();
    #2;
    res_valid_in = 0; res_pc_in = 0; flush_in = 0; res_rd_in = 0; res_data_in = 0;
  endtask

  task automatic cyc(input logic [2:0] rd, input logic [7:0] d, input logic pc);
    res_valid_in = 1; res_rd_in = rd; res_data_in = d; res_pc_in = pc;
    clk_edge();
  endtask

  task automatic look();
    @(negedge clka);
    #1;
  endtask

  always @(negedge clka) begin
    chk("we", we_reg_out, m_we);
    chk("rd", rd_out, m_rd);
    chk("data", data_out, m_data);
    chk("pc_latch", pc_latch_out, m_pc);
    chk("count", count_out, q.size());
    chk("ready", res_ready_out, m_ready());
    chk("stall", stall_out, m_stall());
  end

  initial begin
    reset_in = 1; res_valid_in = 0; res_pc_in = 0; flush_in = 0;
    res_rd_in = 0; res_data_in = 0; sr1_in = 0; sr2_in = 0;
    clk_edge();
    reset_in = 0;
    look();
    chk("rst_we", we_reg_out, 0);
    chk("rst_count", count_out, 0);
    chk("rst_ready", res_ready_out, 1);
    chk("rst_stall", stall_out, 0);
    sr1_in = 7; sr2_in = 7;
    // single write, latency one edge
    cyc(3'd1, 8'h01, 0);
    look();
    chk("single_cnt", count_out, 1);
    chk("single_we0", we_reg_out, 0);
    clk_edge(); look();
    chk("single_we", we_reg_out, 1);
    chk("single_rd", rd_out, 1);
    chk("single_data", data_out, 8'h01);
    clk_edge(); look();
    chk("single_idle", we_reg_out, 0);
    // PC update with rd forced to 0, bubble, then rd=2
    sr2_in = 0;
    cyc(3'd6, 8'h08, 1);
    cyc(3'd2, 8'h02, 0);
    look();
    chk("pc_we", we_reg_out, 1);
    chk("pc_rd", rd_out, 0);
    chk("pc_data", data_out, 8'h08);
    chk("pc_latch", pc_latch_out, 1);
    chk("pc_stall_rd0", stall_out, 1);
    clk_edge(); look();
    chk("bubble_we", we_reg_out, 0);
    chk("bubble_pc", pc_latch_out, 0);
    chk("bubble_stall", stall_out, 0);
    clk_edge(); look();
    chk("after_bubble_rd", rd_out, 2);
    chk("after_bubble_we", we_reg_out, 1);
    sr2_in = 7;
    clk_edge();
    // fill to full behind PC bubbles
    cyc(3'd0, 8'h31, 1);
    cyc(3'd0, 8'h32, 1);
    cyc(3'd0, 8'h33, 1);
    for (int i = 1; i <= 4; i++) cyc(3'(i), 8'(8'h09 + i), 0);
    look();
    chk("full_cnt", count_out, 4);
    chk("full_ready", res_ready_out, 0);
    cyc(3'd7, 8'hEE, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) clk_edge();
      look();
      chk("fill_rd", rd_out, i);
      chk("fill_data", data_out, 8'h09 + i);
      chk("fill_cnt", count_out, 4 - i);
    end
    clk_edge(); look();
    chk("fill_done", we_reg_out, 0);
    // hazard then flush
    sr1_in = 3;
    cyc(3'd0, 8'h40, 1);
    cyc(3'd3, 8'h33, 0);
    look();
    chk("haz_stall", stall_out, 1);
    flush_in = 1; res_valid_in = 1; res_rd_in = 5; res_data_in = 8'h55;
    #1;
    chk("flush_ready", res_ready_out, 0);
    clk_edge(); look();
    chk("flush_cnt", count_out, 0);
    chk("flush_we", we_reg_out, 0);
    chk("flush_stall", stall_out, 0);
    clk_edge(); look();
    chk("flush_nowrite", we_reg_out, 0);
    sr1_in = 7;
    // flush with a write on the outputs
    cyc(3'd1, 8'h61, 0);
    cyc(3'd2, 8'h62, 0);
    look();
    chk("mid_we", we_reg_out, 1);
    chk("mid_rd", rd_out, 1);
    flush_in = 1;
    clk_edge(); look();
    chk("mid_flush_we", we_reg_out, 0);
    chk("mid_flush_cnt", count_out, 0);
    // coalescing behind a PC bubble
    cyc(3'd0, 8'h50, 1);
    cyc(3'd5, 8'h10, 0);
    cyc(3'd5, 8'h20, 0);
    look();
`ifdef WB_COALESCE_EN
    chk("coal_cnt", count_out, 1);
    clk_edge(); look();
    chk("coal_rd", rd_out, 5);
    chk("coal_data", data_out, 8'h20);
    clk_edge(); look();
    chk("coal_single", we_reg_out, 0);
`else
    chk("coal_cnt", count_out, 2);
    clk_edge(); look();
    chk("coal_rd", rd_out, 5);
    chk("coal_data", data_out, 8'h10);
    clk_edge(); look();
    chk("coal_second_we", we_reg_out, 1);
    chk("coal_second_data", data_out, 8'h20);
`endif
    clk_edge(); look();
    // reset mid-drain
    cyc(3'd1, 8'h71, 0);
    cyc(3'd2, 8'h72, 0);
    reset_in = 1;
    clk_edge();
    reset_in = 0;
    look();
    chk("rst2_we", we_reg_out, 0);
    chk("rst2_cnt", count_out, 0);
    chk("rst2_rd", rd_out, 0);
    chk("rst2_data", data_out, 0);
    clk_edge();
    clk_edge();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
